// File: rtl/beam_sweep_ctrl.sv
// beam_sweep_ctrl: capture sequencer and lag sweep for beam direction.
// Optional BEAM_SWEEP_HYST_EN: publish only on two equal sweeps.
module beam_sweep_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int WINDOW     = 30,
  parameter int NUM_LAGS   = 60,
  parameter int DIFF_WIDTH = 21,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  continuous,
  input  logic                  sample_valid,
  output logic                  cap_wr_en,
  output logic [6:0]            cap_wr_addr,
  output logic                  corr_req,
  output logic [5:0]            corr_lag,
  input  logic                  corr_ack,
  input  logic                  diff_valid,
  input  logic [DIFF_WIDTH-1:0] diff_value,
  output logic [5:0]            best_lag,
  output logic [7:0]            led_pattern,
  output logic                  result_valid,
  output logic                  busy,
  output logic                  err
);

  localparam int DEPTH = 3 * WINDOW;
  localparam int WDW   = $clog2(TIMEOUT + 1);

  // Addresses are 7 bits, lags 6 bits with 0x3F reserved.
  if (DEPTH > 128 || NUM_LAGS > 63 || NUM_LAGS < 1 ||
      DATA_WIDTH < 1 || TIMEOUT < 1) begin : g_bad_cfg
    $error("beam_sweep_ctrl: unsupported parameters");
  end

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    REQ,
    WAIT,
    DECIDE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [6:0]            cnt_q;
  logic [5:0]            k_q;
  logic [DIFF_WIDTH-1:0] min_q;
  logic [5:0]            cand_q;
  logic [5:0]            prev_q;
  logic [WDW-1:0]        wd_q;
  logic                  err_q;
  logic [5:0]            best_q;
  logic [7:0]            led_q;
  logic                  rv_q;

  logic run_init;
  logic err_clr;
  logic cnt_inc;
  logic k_inc;
  logic take;
  logic dec;
  logic tmo;
  logic wd_hit;
  logic hyst_match;
  logic publish;

  function automatic logic [7:0] lag_to_led(input logic [5:0] lag);
    logic [7:0] p;
    p = 8'h00;
    unique case (1'b1)
      (lag <= 6'd2):                  p = 8'h01;
      (lag >= 6'd3  && lag <= 6'd9):  p = 8'h02;
      (lag >= 6'd10 && lag <= 6'd19): p = 8'h04;
      (lag >= 6'd20 && lag <= 6'd29): p = 8'h08;
      (lag >= 6'd30 && lag <= 6'd39): p = 8'h10;
      (lag >= 6'd40 && lag <= 6'd49): p = 8'h20;
      (lag >= 6'd50 && lag <= 6'd56): p = 8'h40;
      (lag >= 6'd57 && lag <= 6'd59): p = 8'h80;
      default:                        p = 8'h00;
    endcase
    return p;
  endfunction

  assign wd_hit     = (wd_q == WDW'(TIMEOUT - 1));
  assign hyst_match = (cand_q == prev_q);

`ifdef BEAM_SWEEP_HYST_EN
  assign publish = hyst_match;
`else
  // Previous candidate is still tracked but never gates publishing.
  assign publish = hyst_match | 1'b1;
`endif

  assign busy         = (state_q != IDLE);
  assign cap_wr_addr  = cnt_q;
  assign corr_lag     = k_q;
  assign best_lag     = best_q;
  assign led_pattern  = led_q;
  assign result_valid = rv_q;
  assign err          = err_q;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode and per-state strobes.
  always_comb begin
    state_d   = state_q;
    cap_wr_en = 1'b0;
    corr_req  = 1'b0;
    run_init  = 1'b0;
    err_clr   = 1'b0;
    cnt_inc   = 1'b0;
    k_inc     = 1'b0;
    take      = 1'b0;
    dec       = 1'b0;
    tmo       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = CAPTURE;
          run_init = 1'b1;
          err_clr  = 1'b1;
        end
      end
      CAPTURE: begin
        if (sample_valid) begin
          cap_wr_en = 1'b1;
          cnt_inc   = 1'b1;
          if (cnt_q == 7'(DEPTH - 1)) state_d = REQ;
        end
      end
      REQ: begin
        corr_req = 1'b1;
        if (corr_ack) begin
          state_d = WAIT;
        end else if (wd_hit) begin
          state_d = IDLE;
          tmo     = 1'b1;
        end
      end
      WAIT: begin
        if (diff_valid) begin
          take = 1'b1;
          if (k_q == 6'(NUM_LAGS - 1)) begin
            state_d = DECIDE;
          end else begin
            k_inc   = 1'b1;
            state_d = REQ;
          end
        end else if (wd_hit) begin
          state_d = IDLE;
          tmo     = 1'b1;
        end
      end
      DECIDE: begin
        dec = 1'b1;
        if (continuous) begin
          state_d  = CAPTURE;
          run_init = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture count, lag index and running minimum.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      k_q    <= '0;
      min_q  <= '1;
      cand_q <= '0;
    end else if (run_init) begin
      cnt_q  <= '0;
      k_q    <= '0;
      min_q  <= '1;
      cand_q <= '0;
    end else begin
      if (cnt_inc) cnt_q <= cnt_q + 7'd1;
      if (k_inc)   k_q   <= k_q + 6'd1;
      if (take && (diff_value < min_q)) begin
        min_q  <= diff_value;
        cand_q <= k_q;
      end
    end
  end

  // Handshake watchdog, restarted on every state change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_q <= '0;
    end else if ((state_d != state_q) ||
                 !((state_q == REQ) || (state_q == WAIT))) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_q + WDW'(1);
    end
  end

  // Sticky timeout flag, cleared by a fresh start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        err_q <= 1'b0;
    else if (err_clr) err_q <= 1'b0;
    else if (tmo)     err_q <= 1'b1;
  end

  // Result publish and previous-candidate memory.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      best_q <= '0;
      led_q  <= 8'h00;
      rv_q   <= 1'b0;
      prev_q <= 6'h3F;
    end else begin
      rv_q <= 1'b0;
      if (dec) begin
        prev_q <= cand_q;
        if (publish) begin
          best_q <= cand_q;
          led_q  <= lag_to_led(cand_q);
          rv_q   <= 1'b1;
        end
      end
    end
  end

endmodule
